// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file:
// address-width derivation, address liveness and write-port priority resolution.
package regfile_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NREG     = 32;
  localparam int MAX_WR_PORTS = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } prio_t;

  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // An address is live when it names a real register that is not the hardwired zero.
  function automatic logic addr_live(input int addr, input int nreg, input bit zero_reg);
    return (addr < nreg) && !(zero_reg && addr == 0);
  endfunction

  // Highest set bit wins: later write ports override earlier ones.
  function automatic prio_t prio_resolve(input logic [MAX_WR_PORTS-1:0] match);
    prio_t r;
    r = '0;
    for (int j = 0; j < MAX_WR_PORTS; j++) begin
      if (match[j]) begin
        r.hit = 1'b1;
        r.idx = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush clears all.
// rbusy is masked by any same-cycle writeback to the read address.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG     = DEF_NREG,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = addr_width(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NRD*AW-1:0] raddr,
  input  logic [NWR-1:0]  we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic [NRD-1:0]  rbusy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW-1:0]   rd_a;
  logic            wr_hit;

  // Set after clear so a new producer supersedes the retiring one; flush overrides both.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && int'(waddr[j*AW +: AW]) < NREG) busy_nxt[waddr[j*AW +: AW]] = 1'b0;
    end
    if (iss_valid && addr_live(int'(iss_rd), NREG, ZERO_REG)) busy_nxt[iss_rd] = 1'b1;
    if (flush) busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  always_comb begin
    rbusy  = '0;
    rd_a   = '0;
    wr_hit = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rd_a   = raddr[i*AW +: AW];
      wr_hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && waddr[j*AW +: AW] == rd_a) wr_hit = 1'b1;
      end
      rbusy[i] = addr_live(int'(rd_a), NREG, ZERO_REG) && busy[rd_a] && !wr_hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard,
// sitting at the decode/writeback boundary.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREG     = DEF_NREG,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_width(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush
);

  logic [XLEN-1:0]         mem [NREG];
  logic [AW-1:0]           rd_a;
  logic [MAX_WR_PORTS-1:0] rd_match;
  prio_t                   rd_prio;

  // NOTE: the array is built from flops, not an SRAM macro, so it takes the async
  // reset like any other state; an SRAM-backed variant would have to drop this.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      // Ports are visited low to high, so the last non-blocking write to an address wins.
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && addr_live(int'(waddr[j*AW +: AW]), NREG, ZERO_REG))
          mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
      end
    end
  end

  // NOTE: blocking assignments here are intentional; always_comb evaluates top to
  // bottom and every variable gets a default first, so no latch is inferred.
  always_comb begin
    rdata    = '0;
    rd_a     = '0;
    rd_match = '0;
    rd_prio  = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_a     = raddr[i*AW +: AW];
      rd_match = '0;
      for (int j = 0; j < NWR; j++) rd_match[j] = we[j] && (waddr[j*AW +: AW] == rd_a);
      rd_prio  = prio_resolve(rd_match);
      // Held reset forces zero even if a bypass source is active.
      if (rst && addr_live(int'(rd_a), NREG, ZERO_REG))
        rdata[i*XLEN +: XLEN] = rd_prio.hit ? wdata[int'(rd_prio.idx)*XLEN +: XLEN] : mem[rd_a];
    end
  end

  rf_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr),
    .we        (we),
    .waddr     (waddr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .rbusy     (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus pushes hand-computed expectations into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_regfile_mp;

  localparam int AW = 5;

  logic        clk;
  logic        rst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  // Monitor: outputs are combinational, so every driven vector is valid at the next negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".rdata0"}, rdata[31:0],  e.d0);
      check({e.name, ".rdata1"}, rdata[63:32], e.d1);
      check({e.name, ".rbusy"},  {30'd0, rbusy}, {30'd0, e.busy});
    end
  end

  task automatic apply(
    input string nm, input logic r,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [1:0] w,
    input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1,
    input logic iv, input logic [4:0] ird, input logic fl,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    raddr     = {ra1, ra0};
    we        = w;
    waddr     = {wa1, wa0};
    wdata     = {wd1, wd0};
    iss_valid = iv;
    iss_rd    = ird;
    flush     = fl;
    e.name = nm; e.d0 = e0; e.d1 = e1; e.busy = eb;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; raddr = '0; we = '0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    #1 rst = 1'b0;

    //     name              rst ra0 ra1 we     wa0  wd0           wa1 wd1           iv ird fl  exp d0        exp d1        busy
    apply("reset_idle",      0,  0,  5, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h0,        32'h0,        2'b00);
    apply("reset_bypass",    0,  7,  7, 2'b10,  0, 32'h0,         7, 32'hDEADBEEF,  1, 7,  0, 32'h0,        32'h0,        2'b00);
    apply("write_x5",        1,  5,  7, 2'b01,  5, 32'h12345678,  0, 32'h0,         0, 0,  0, 32'h12345678, 32'h0,        2'b00);
    apply("read_x5",         1,  5,  0, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h12345678, 32'h0,        2'b00);
    apply("bypass_p1",       1,  7,  5, 2'b10,  0, 32'h0,         7, 32'hDEADBEEF,  0, 0,  0, 32'hDEADBEEF, 32'h12345678, 2'b00);
    apply("conflict_x3",     1,  3,  7, 2'b11,  3, 32'h1111,      3, 32'h2222,      0, 0,  0, 32'h2222,     32'hDEADBEEF, 2'b00);
    apply("conflict_read",   1,  3,  3, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h2222,     32'h2222,     2'b00);
    apply("two_port_write",  1,  4,  6, 2'b11,  4, 32'hAAAA,      6, 32'hBBBB,      0, 0,  0, 32'hAAAA,     32'hBBBB,     2'b00);
    apply("zero_write",      1,  0,  4, 2'b01,  0, 32'hFFFFFFFF,  0, 32'h0,         1, 0,  0, 32'h0,        32'hAAAA,     2'b00);
    apply("zero_after",      1,  0,  0, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h0,        32'h0,        2'b00);
    apply("iss_x9",          1,  9,  4, 2'b00,  0, 32'h0,         0, 32'h0,         1, 9,  0, 32'h0,        32'hAAAA,     2'b00);
    apply("busy_x9",         1,  9,  4, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h0,        32'hAAAA,     2'b01);
    apply("wb_and_iss_x9",   1,  9,  9, 2'b01,  9, 32'h99,        0, 32'h0,         1, 9,  0, 32'h99,       32'h99,       2'b00);
    apply("still_busy_x9",   1,  9,  5, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h99,       32'h12345678, 2'b01);
    apply("wb_only_x9",      1,  9,  9, 2'b10,  0, 32'h0,         9, 32'h9999,      0, 0,  0, 32'h9999,     32'h9999,     2'b00);
    apply("cleared_x9",      1,  9,  1, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h9999,     32'h0,        2'b00);
    apply("iss_x1",          1,  1,  2, 2'b00,  0, 32'h0,         0, 32'h0,         1, 1,  0, 32'h0,        32'h0,        2'b00);
    apply("iss_x2",          1,  1,  2, 2'b00,  0, 32'h0,         0, 32'h0,         1, 2,  0, 32'h0,        32'h0,        2'b01);
    apply("iss_x3",          1,  1,  2, 2'b00,  0, 32'h0,         0, 32'h0,         1, 3,  0, 32'h0,        32'h0,        2'b11);
    apply("busy_x3",         1,  3,  4, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h2222,     32'hAAAA,     2'b01);
    apply("flush_iss_x4",    1,  3, 10, 2'b01, 10, 32'hCAFE,      0, 32'h0,         1, 4,  1, 32'h2222,     32'hCAFE,     2'b01);
    apply("after_flush_34",  1,  3,  4, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h2222,     32'hAAAA,     2'b00);
    apply("after_flush_12",  1,  1,  2, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h0,        32'h0,        2'b00);
    apply("pre_reset_iss",   1,  5, 10, 2'b00,  0, 32'h0,         0, 32'h0,         1, 5,  0, 32'h12345678, 32'hCAFE,     2'b00);
    apply("reset_mid_write", 0,  5, 10, 2'b01,  5, 32'h5555,      0, 32'h0,         0, 0,  0, 32'h0,        32'h0,        2'b00);
    apply("after_reset",     1,  5, 10, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h0,        32'h0,        2'b00);
    apply("first_edge_wr",   1,  5,  9, 2'b01,  5, 32'h5555,      0, 32'h0,         0, 0,  0, 32'h5555,     32'h0,        2'b00);
    apply("first_edge_rd",   1,  5,  3, 2'b00,  0, 32'h0,         0, 32'h0,         0, 0,  0, 32'h5555,     32'h0,        2'b00);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with same-cycle write-to-read bypass and a per-register busy scoreboard. Sits in the decode/writeback boundary of the pipeline. Decode reads operands and marks destinations busy. Writeback ports retire results and clear busy bits. Supports multiple read and write ports so a dual-issue or split-writeback (ALU + load) datapath uses one block.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers
- NRD, 2, number of read ports
- NWR, 2, number of write ports; higher index = higher priority
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes and busy marks
- AW, $clog2(NREG), address width (derived, not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- raddr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rdata  out  NRD*XLEN  read data, combinational
- rbusy  out  NRD  read register has an outstanding producer
- we  in  NWR  write enables
- waddr  in  NWR*AW  write addresses
- wdata  in  NWR*XLEN  write data
- iss_valid  in  1  decode issues an instruction with a destination
- iss_rd  in  AW  destination to mark busy
- flush  in  1  pipeline flush; clears all busy bits

## Operation
- Reset (rst=0): all registers and busy bits cleared asynchronously. rdata = 0 and rbusy = 0 for every port while reset is held.
- Write: on a rising edge, each port j with we[j]=1 writes wdata[j] to waddr[j].
  - With ZERO_REG=1, a write to address 0 is dropped.
  - Two ports writing the same address in one cycle: the highest-index port wins, and the other write is discarded.
- Read: rdata[i] = 0 if ZERO_REG and raddr[i]==0.
  - Else, if any write port this cycle has we=1 and waddr==raddr[i], the bypass returns the wdata of the highest-index such port.
  - Else, the stored value.
- Scoreboard:
  - Busy set: iss_valid=1 sets busy[iss_rd] at the edge. Skipped for address 0 when ZERO_REG=1.
  - Busy clear: any we[j]=1 clears busy[waddr[j]] at the edge.
  - Set and clear of the same register in one cycle: set wins, because the new producer supersedes the old one.
  - flush=1 clears every busy bit and overrides iss_valid in the same cycle. Register writes in that cycle still occur.
- rbusy[i] = busy[raddr[i]] AND NOT (a write this cycle targets raddr[i]). Forced 0 for address 0 when ZERO_REG=1.
  - Same-cycle writeback therefore makes the operand ready via the bypass.
  - The same cycle's iss_valid does not raise rbusy until the next cycle.
- No display/trace side effects in RTL.

## Timing
- Read latency: 0 cycles, combinational from raddr/we/waddr/wdata.
- Write latency: 1 edge. The stored value is visible without bypass from the cycle after we.
- Busy set latency: 1 edge after iss_valid. Busy clear latency: 0 cycles as seen on rbusy (masked), 1 edge in state.
- Reset deassertion mid-stream: the first edge with rst=1 performs normal writes and issues.
- All address inputs are assumed below NREG. Addresses at or above NREG (non-power-of-two NREG) are ignored on write and read 0 and not busy.

## Structure
- Package regfile_pkg: default XLEN/NREG constants, the clog2-based AW helper, and a write-port priority-resolve function.
- Sub-module rf_scoreboard: busy vector, set/clear/flush logic, masked rbusy per read port. Instantiated once.
- Storage array and bypass muxes stay in regfile_mp. No generate-dependent behaviour beyond port loops.

## Test plan
- Reset, then read all ports -> rdata=0, rbusy=0; write x5=0x12345678 on port 0, next cycle read x5 -> 0x12345678.
- Same-cycle bypass: we[1]=1 waddr=7 wdata=0xDEADBEEF while raddr0=7 -> rdata0=0xDEADBEEF in that cycle, before the edge.
- Write conflict: port0 x3=0x1111, port1 x3=0x2222 same cycle -> next cycle x3=0x2222; bypass that cycle also returns 0x2222.
- Zero register: write x0=0xFFFFFFFF and iss_rd=0 -> rdata for x0 = 0, rbusy = 0.
- Scoreboard: iss x9 -> next cycle rbusy for x9 = 1. Writeback x9 with iss x9 in the same cycle -> busy remains 1. Then writeback only -> rbusy=0 in that same cycle (masked), state clear after the edge.
- Flush/reset: mark x1, x2, x3 busy, assert flush with iss x4 -> all busy 0 next cycle. Assert rst mid-write -> registers 0 immediately, no write lands.
